// File: rtl/iterative_divider_if.sv
// Start/Busy/Done handshake and operand/result bus for the iterative divider.
// The ALU control FSM takes the master side; the divider takes the slave side.
interface iterative_divider_if #(
   parameter int WIDTH = 4
);
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] R;
   logic             DivZero;

   modport master (
      output Start, A, B,
      input  Busy, Done, Q, R, DivZero
   );

   modport slave (
      input  Start, A, B,
      output Busy, Done, Q, R, DivZero
   );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtract and one quotient bit per clock.
// Q = A / B, R = A % B; divide-by-zero returns all-ones quotient, R = A, DivZero = 1.
module iterative_divider #(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   iterative_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic             dz_pend;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // NOTE: the trial is one bit wider than the operands so its MSB is the borrow.
   always_comb begin
      shifted = {rem, dvd[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
      borrow  = trial[WIDTH];
      rem_nxt = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nxt = {dvd[WIDTH-2:0], ~borrow};
   end

   // dvd doubles as the quotient shift register: dividend bits leave the top,
   // quotient bits enter the bottom.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         dvd         <= '0;
         dvs         <= '0;
         dz_pend     <= 1'b0;
         bus.Busy    <= 1'b0;
         bus.Done    <= 1'b0;
         bus.Q       <= '0;
         bus.R       <= '0;
         bus.DivZero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.Done <= 1'b0;
               if (bus.Start) begin
                  dvd <= bus.A;
                  if (bus.B != '0) begin
                     dvs      <= bus.B;
                     rem      <= '0;
                     cnt      <= CW'(WIDTH);
                     bus.Busy <= 1'b1;
                     state    <= RUN;
                  end else begin
                     dz_pend <= 1'b1;
                     state   <= FIN;
                  end
               end
            end
            RUN: begin
               dvd <= quo_nxt;
               rem <= rem_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  bus.Busy    <= 1'b0;
                  bus.Done    <= 1'b1;
                  bus.Q       <= quo_nxt;
                  bus.R       <= rem_nxt;
                  bus.DivZero <= 1'b0;
                  state       <= FIN;
               end
            end
            FIN: begin
               // Divide-by-zero spends one extra FIN cycle before publishing its result.
               if (dz_pend) begin
                  dz_pend     <= 1'b0;
                  bus.Done    <= 1'b1;
                  bus.Q       <= '1;
                  bus.R       <= dvd;
                  bus.DivZero <= 1'b1;
               end else begin
                  bus.Done <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
